dru_lock_ctrl: RTL and testbench
================================

Name: dru_lock_ctrl

Overview:
Sequencing controller for the technology-wrapped oversampling data recovery unit (DRU).
- Drives the DRU reset, frequency reset, enable, loop gains and centre frequency.
- Runs acquisition with high gain, then switches to tracking gain once lock is qualified.
- Monitors AL_PPM and the recovered-bit rate (SAMV); on loss of lock it forces a relock sequence.
- Sits between the link configuration registers and the DRU instance.

Parameters:
- RST_CYCLES, 16: cycles that DRU RST/RST_FREQ are held in state RESET.
- WIN_LEN, 1024: cycles per rate-check window.
- EXP_BITS, 5120: expected sum of SAMV over one window.
- TOL, 64: allowed absolute deviation of the window sum from EXP_BITS.
- LOCK_WINDOWS, 4: consecutive good windows needed to declare lock.
- ACQ_TIMEOUT, 64: windows in ACQ without lock before alarm.
- ALARM_FILT, 8: consecutive AL_PPM-high cycles in TRACK that trigger alarm.

Ports:
- CLK  in  1  system clock; same clock as the DRU.
- RST  in  1  asynchronous active-high reset.
- i_start  in  1  level; request start or continued operation.
- i_stop  in  1  pulse; return to IDLE.
- i_center_f  in  37  configured centre frequency.
- i_g1_acq  in  5  G1 used during acquisition.
- i_g1_trk  in  5  G1 used during tracking.
- i_g1_p  in  5  G1_P passthrough.
- i_g2  in  5  G2 passthrough.
- i_al_ppm  in  1  DRU AL_PPM.
- i_samv  in  4  DRU SAMV, valid bits this cycle (0..10).
- o_dru_en  out  1  DRU EN.
- o_dru_rst  out  1  DRU RST.
- o_dru_rst_freq  out  1  DRU RST_FREQ.
- o_g1  out  5  DRU G1.
- o_g1_p  out  5  DRU G1_P.
- o_g2  out  5  DRU G2.
- o_center_f  out  37  DRU CENTER_F.
- o_locked  out  1  high in TRACK only.
- o_state  out  3  IDLE=0, RESET=1, ACQ=2, TRACK=3, ALARM=4.
- o_relock_cnt  out  8  count of ALARM entries, saturating at 255.

Behaviour:
- All outputs are registered.
- Reset values: state IDLE; o_dru_en=0, o_dru_rst=1, o_dru_rst_freq=1, o_g1=0, o_g1_p=0, o_g2=0, o_center_f=0, o_locked=0, o_relock_cnt=0.
- Config capture: i_center_f, i_g1_p, i_g2 and both G1 values are captured on the IDLE->RESET transition and held until the next start. Mid-run config changes are ignored.
- IDLE:
  - o_dru_en=0, rst=1, rst_freq=1.
  - Goes to RESET when i_start=1.
- RESET:
  - rst=1 and rst_freq=1 for exactly RST_CYCLES cycles, then ACQ.
  - Window counter, good counter and timeout counter are cleared.
- ACQ:
  - en=1, rst=0, rst_freq=0, o_g1=g1_acq.
  - Window logic: counter runs 0..WIN_LEN-1; sum += i_samv, saturating at 16 bits. A sticky flag records any i_al_ppm=1 in the window.
  - At the last window cycle, the window is good iff the flag is 0 and |sum-EXP_BITS| <= TOL. The sum and flag restart on the next cycle; the current cycle's SAMV is included in the closing window.
  - Good window: good_cnt++. Bad window: good_cnt=0.
  - When good_cnt reaches LOCK_WINDOWS, go to TRACK on the next cycle.
  - After ACQ_TIMEOUT windows completed without lock, go to ALARM.
- TRACK:
  - o_g1=g1_trk, o_locked=1.
  - Windowing continues; any bad window goes to ALARM.
  - An AL_PPM run of ALARM_FILT consecutive high cycles goes to ALARM. The run counter clears on any low cycle.
- ALARM:
  - One cycle: o_locked=0, en=0, o_relock_cnt saturating +1.
  - Next state is RESET if i_start=1, else IDLE.
- Priority, highest first: RST, i_stop (from any state to IDLE next cycle), then normal transitions. Simultaneous window-good completion and AL_PPM filter expiry in TRACK resolves to ALARM.
- The G1 switch to g1_trk takes effect in the same cycle o_locked rises.
- Width rules:
  - window counter: clog2(WIN_LEN) bits.
  - good counter: clog2(LOCK_WINDOWS+1) bits.
  - timeout counter: clog2(ACQ_TIMEOUT+1) bits.
  - All counters are unsigned; comparison uses the 17-bit signed difference.

Decomposition:
- Package dru_ctrl_pkg holds:
  - state enum (3-bit encoding as above);
  - DRU config struct (center_f, g1_acq, g1_trk, g1_p, g2);
  - default parameter constants.
- One sub-module: dru_rate_window. It holds the window counter, SAMV accumulator and AL_PPM sticky flag, and outputs a win_done/win_good pulse pair. It is cleared by the FSM.

Test Plan:
- Reset then i_start=1 with SAMV constant 5 and AL_PPM=0 -> o_dru_rst high exactly 16 cycles; o_locked rises after 4×1024 cycles in ACQ; o_g1 switches from g1_acq to g1_trk in the same cycle.
- Locked, AL_PPM high for 7 cycles then low -> stays TRACK. AL_PPM high for 8 cycles -> ALARM, o_relock_cnt=1, then RESET with 16 rst cycles.
- In ACQ, SAMV sum=5184 (within TOL) passes; sum=5185 fails and resets good_cnt; the third window bad -> lock is delayed by a further 4 windows.
- SAMV=0 continuously -> ALARM after exactly 64 windows (65536 ACQ cycles), then relock; force 300 alarms -> o_relock_cnt saturates at 255.
- i_stop pulse in ACQ and in TRACK -> IDLE next cycle, en=0, rst=1; i_center_f changed while in TRACK -> o_center_f unchanged until the next start.
- Assert RST mid-TRACK -> all outputs at reset values asynchronously; o_relock_cnt=0.

Source files
------------

// File: rtl/dru_ctrl_pkg.sv
// Shared types and constants for the DRU lock controller: state encoding,
// captured link configuration, default timing constants and the helper
// that judges a closed rate window against its expected bit count.
package dru_ctrl_pkg;

    localparam int DEF_RST_CYCLES   = 16;
    localparam int DEF_WIN_LEN      = 1024;
    localparam int DEF_EXP_BITS     = 5120;
    localparam int DEF_TOL          = 64;
    localparam int DEF_LOCK_WINDOWS = 4;
    localparam int DEF_ACQ_TIMEOUT  = 64;
    localparam int DEF_ALARM_FILT   = 8;

    localparam int CF_W   = 37;
    localparam int GAIN_W = 5;
    localparam int SAMV_W = 4;
    localparam int SUM_W  = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RESET = 3'd1,
        ST_ACQ   = 3'd2,
        ST_TRACK = 3'd3,
        ST_ALARM = 3'd4
    } dru_state_e;

    typedef struct packed {
        logic [CF_W-1:0]   center_f;
        logic [GAIN_W-1:0] g1_acq;
        logic [GAIN_W-1:0] g1_trk;
        logic [GAIN_W-1:0] g1_p;
        logic [GAIN_W-1:0] g2;
    } dru_cfg_t;

    // True when |sum - exp_bits| <= tol, evaluated as a 17-bit signed difference
    function automatic logic win_in_tol(input logic [SUM_W-1:0] sum,
                                        input int               exp_bits,
                                        input int               tol);
        logic signed [SUM_W:0] diff;
        logic signed [SUM_W:0] mag;
        diff = $signed({1'b0, sum}) - $signed((SUM_W+1)'(exp_bits));
        mag  = diff[SUM_W] ? -diff : diff;
        return (mag <= $signed((SUM_W+1)'(tol)));
    endfunction

endpackage

// File: rtl/dru_rate_window.sv
// Rate-check window for the DRU: counts WIN_LEN cycles, accumulates SAMV
// with 16-bit saturation and remembers any AL_PPM assertion. In the last
// window cycle it raises win_done, plus win_good when the window (including
// that cycle's inputs) is clean and within tolerance. Held clear by the FSM
// whenever the DRU is not running.
module dru_rate_window
    import dru_ctrl_pkg::*;
#(
    parameter int WIN_LEN  = DEF_WIN_LEN,
    parameter int EXP_BITS = DEF_EXP_BITS,
    parameter int TOL      = DEF_TOL
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              i_clr,
    input  logic [SAMV_W-1:0] i_samv,
    input  logic              i_al_ppm,
    output logic              o_win_done,
    output logic              o_win_good
);

    localparam int WIN_CW = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;

    logic [WIN_CW-1:0] r_cnt;
    logic [SUM_W-1:0]  r_sum;
    logic              r_flag;

    logic [SUM_W:0]    w_add;
    logic [SUM_W-1:0]  w_sum_next;
    logic              w_flag_next;
    logic              w_last;

    // Next accumulator/flag values and the end-of-window verdict
    always_comb begin
        w_add = {1'b0, r_sum} + {{(SUM_W+1-SAMV_W){1'b0}}, i_samv};
        if (w_add[SUM_W]) begin
            w_sum_next = {SUM_W{1'b1}};
        end else begin
            w_sum_next = w_add[SUM_W-1:0];
        end
        w_flag_next = r_flag | i_al_ppm;
        w_last      = (r_cnt == WIN_CW'(WIN_LEN - 1));
        o_win_done  = w_last & ~i_clr;
        o_win_good  = o_win_done & ~w_flag_next & win_in_tol(w_sum_next, EXP_BITS, TOL);
    end

    // Window counter, accumulator and sticky flag; restart after the last cycle
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt  <= {WIN_CW{1'b0}};
            r_sum  <= {SUM_W{1'b0}};
            r_flag <= 1'b0;
        end else if (i_clr || w_last) begin
            r_cnt  <= {WIN_CW{1'b0}};
            r_sum  <= {SUM_W{1'b0}};
            r_flag <= 1'b0;
        end else begin
            r_cnt  <= r_cnt + WIN_CW'(1);
            r_sum  <= w_sum_next;
            r_flag <= w_flag_next;
        end
    end

endmodule

// File: rtl/dru_lock_ctrl.sv
// DRU lock controller: sequences reset, high-gain acquisition and
// low-gain tracking of the oversampling data recovery unit, watches the
// recovered bit rate and AL_PPM, and forces a relock through ALARM when
// lock is lost. Link configuration is captured when leaving IDLE.
module dru_lock_ctrl
    import dru_ctrl_pkg::*;
#(
    parameter int RST_CYCLES   = DEF_RST_CYCLES,
    parameter int WIN_LEN      = DEF_WIN_LEN,
    parameter int EXP_BITS     = DEF_EXP_BITS,
    parameter int TOL          = DEF_TOL,
    parameter int LOCK_WINDOWS = DEF_LOCK_WINDOWS,
    parameter int ACQ_TIMEOUT  = DEF_ACQ_TIMEOUT,
    parameter int ALARM_FILT   = DEF_ALARM_FILT
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic [CF_W-1:0]   i_center_f,
    input  logic [GAIN_W-1:0] i_g1_acq,
    input  logic [GAIN_W-1:0] i_g1_trk,
    input  logic [GAIN_W-1:0] i_g1_p,
    input  logic [GAIN_W-1:0] i_g2,
    input  logic              i_al_ppm,
    input  logic [SAMV_W-1:0] i_samv,
    output logic              o_dru_en,
    output logic              o_dru_rst,
    output logic              o_dru_rst_freq,
    output logic [GAIN_W-1:0] o_g1,
    output logic [GAIN_W-1:0] o_g1_p,
    output logic [GAIN_W-1:0] o_g2,
    output logic [CF_W-1:0]   o_center_f,
    output logic              o_locked,
    output logic [2:0]        o_state,
    output logic [7:0]        o_relock_cnt
);

    localparam int RST_CW  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int GOOD_CW = $clog2(LOCK_WINDOWS + 1);
    localparam int TO_CW   = $clog2(ACQ_TIMEOUT + 1);
    localparam int FILT_CW = $clog2(ALARM_FILT + 1);

    dru_state_e         r_state;
    dru_state_e         w_next_state;
    dru_cfg_t           r_cfg;
    dru_cfg_t           w_cfg_next;
    logic               w_capture;

    logic [RST_CW-1:0]  r_rst_cnt;
    logic [GOOD_CW-1:0] r_good_cnt;
    logic [TO_CW-1:0]   r_to_cnt;
    logic [FILT_CW-1:0] r_ppm_run;

    logic               w_win_clr;
    logic               w_win_done;
    logic               w_win_good;
    logic               w_lock_hit;
    logic               w_timeout_hit;
    logic               w_ppm_hit;

    logic               r_dru_en;
    logic               r_dru_rst;
    logic               r_dru_rst_freq;
    logic [GAIN_W-1:0]  r_g1;
    logic               r_locked;
    logic [7:0]         r_relock_cnt;

    // Windows only run while the DRU is enabled and acquiring or tracking
    assign w_win_clr = ~((r_state == ST_ACQ) || (r_state == ST_TRACK));

    dru_rate_window #(
        .WIN_LEN  (WIN_LEN),
        .EXP_BITS (EXP_BITS),
        .TOL      (TOL)
    ) u_rate_window (
        .CLK        (CLK),
        .RST        (RST),
        .i_clr      (w_win_clr),
        .i_samv     (i_samv),
        .i_al_ppm   (i_al_ppm),
        .o_win_done (w_win_done),
        .o_win_good (w_win_good)
    );

    // Event qualifiers: lock reached, acquisition timed out, AL_PPM run expired
    always_comb begin
        w_lock_hit    = w_win_done & w_win_good &
                        (r_good_cnt == GOOD_CW'(LOCK_WINDOWS - 1));
        w_timeout_hit = w_win_done & (r_to_cnt == TO_CW'(ACQ_TIMEOUT - 1));
        w_ppm_hit     = (r_state == ST_TRACK) & i_al_ppm &
                        (r_ppm_run == FILT_CW'(ALARM_FILT - 1));
    end

    // Next-state logic; stop beats everything, lock beats timeout
    always_comb begin
        w_next_state = r_state;
        if (i_stop) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) w_next_state = ST_RESET;
                    else         w_next_state = ST_IDLE;
                end
                ST_RESET: begin
                    if (r_rst_cnt == RST_CW'(RST_CYCLES - 1)) w_next_state = ST_ACQ;
                    else                                      w_next_state = ST_RESET;
                end
                ST_ACQ: begin
                    if (w_lock_hit)         w_next_state = ST_TRACK;
                    else if (w_timeout_hit) w_next_state = ST_ALARM;
                    else                    w_next_state = ST_ACQ;
                end
                ST_TRACK: begin
                    if (w_ppm_hit || (w_win_done && !w_win_good)) w_next_state = ST_ALARM;
                    else                                          w_next_state = ST_TRACK;
                end
                ST_ALARM: begin
                    if (i_start) w_next_state = ST_RESET;
                    else         w_next_state = ST_IDLE;
                end
                default: w_next_state = ST_IDLE;
            endcase
        end
    end

    // Configuration is only sampled when a fresh start leaves IDLE
    always_comb begin
        w_capture = (r_state == ST_IDLE) && (w_next_state == ST_RESET);
        if (w_capture) begin
            w_cfg_next.center_f = i_center_f;
            w_cfg_next.g1_acq   = i_g1_acq;
            w_cfg_next.g1_trk   = i_g1_trk;
            w_cfg_next.g1_p     = i_g1_p;
            w_cfg_next.g2       = i_g2;
        end else begin
            w_cfg_next = r_cfg;
        end
    end

    // State and captured configuration registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_cfg   <= {$bits(dru_cfg_t){1'b0}};
        end else begin
            r_state <= w_next_state;
            r_cfg   <= w_cfg_next;
        end
    end

    // Sequencing counters: reset hold, good-window run, ACQ timeout, AL_PPM run
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_rst_cnt  <= {RST_CW{1'b0}};
            r_good_cnt <= {GOOD_CW{1'b0}};
            r_to_cnt   <= {TO_CW{1'b0}};
            r_ppm_run  <= {FILT_CW{1'b0}};
        end else begin
            if ((r_state == ST_RESET) && (w_next_state == ST_RESET)) begin
                r_rst_cnt <= r_rst_cnt + RST_CW'(1);
            end else begin
                r_rst_cnt <= {RST_CW{1'b0}};
            end

            if (r_state == ST_ACQ) begin
                if (w_win_done) begin
                    r_good_cnt <= w_win_good ? (r_good_cnt + GOOD_CW'(1)) : {GOOD_CW{1'b0}};
                    r_to_cnt   <= r_to_cnt + TO_CW'(1);
                end else begin
                    r_good_cnt <= r_good_cnt;
                    r_to_cnt   <= r_to_cnt;
                end
            end else begin
                r_good_cnt <= {GOOD_CW{1'b0}};
                r_to_cnt   <= {TO_CW{1'b0}};
            end

            if ((r_state == ST_TRACK) && i_al_ppm) begin
                if (r_ppm_run != FILT_CW'(ALARM_FILT)) r_ppm_run <= r_ppm_run + FILT_CW'(1);
                else                                   r_ppm_run <= r_ppm_run;
            end else begin
                r_ppm_run <= {FILT_CW{1'b0}};
            end
        end
    end

    // Registered DRU controls for the state being entered, plus relock count
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_dru_en       <= 1'b0;
            r_dru_rst      <= 1'b1;
            r_dru_rst_freq <= 1'b1;
            r_g1           <= {GAIN_W{1'b0}};
            r_locked       <= 1'b0;
            r_relock_cnt   <= 8'd0;
        end else begin
            case (w_next_state)
                ST_IDLE: begin
                    r_dru_en       <= 1'b0;
                    r_dru_rst      <= 1'b1;
                    r_dru_rst_freq <= 1'b1;
                    r_g1           <= {GAIN_W{1'b0}};
                    r_locked       <= 1'b0;
                end
                ST_RESET: begin
                    r_dru_en       <= 1'b0;
                    r_dru_rst      <= 1'b1;
                    r_dru_rst_freq <= 1'b1;
                    r_g1           <= w_cfg_next.g1_acq;
                    r_locked       <= 1'b0;
                end
                ST_ACQ: begin
                    r_dru_en       <= 1'b1;
                    r_dru_rst      <= 1'b0;
                    r_dru_rst_freq <= 1'b0;
                    r_g1           <= w_cfg_next.g1_acq;
                    r_locked       <= 1'b0;
                end
                ST_TRACK: begin
                    r_dru_en       <= 1'b1;
                    r_dru_rst      <= 1'b0;
                    r_dru_rst_freq <= 1'b0;
                    r_g1           <= w_cfg_next.g1_trk;
                    r_locked       <= 1'b1;
                end
                ST_ALARM: begin
                    r_dru_en       <= 1'b0;
                    r_dru_rst      <= 1'b0;
                    r_dru_rst_freq <= 1'b0;
                    r_g1           <= w_cfg_next.g1_acq;
                    r_locked       <= 1'b0;
                end
                default: begin
                    r_dru_en       <= 1'b0;
                    r_dru_rst      <= 1'b1;
                    r_dru_rst_freq <= 1'b1;
                    r_g1           <= {GAIN_W{1'b0}};
                    r_locked       <= 1'b0;
                end
            endcase

            if ((w_next_state == ST_ALARM) && (r_state != ST_ALARM) &&
                (r_relock_cnt != 8'hFF)) begin
                r_relock_cnt <= r_relock_cnt + 8'd1;
            end else begin
                r_relock_cnt <= r_relock_cnt;
            end
        end
    end

    assign o_state        = r_state;
    assign o_dru_en       = r_dru_en;
    assign o_dru_rst      = r_dru_rst;
    assign o_dru_rst_freq = r_dru_rst_freq;
    assign o_g1           = r_g1;
    assign o_g1_p         = r_cfg.g1_p;
    assign o_g2           = r_cfg.g2;
    assign o_center_f     = r_cfg.center_f;
    assign o_locked       = r_locked;
    assign o_relock_cnt   = r_relock_cnt;

endmodule

// File: tb/tb_dru_lock_ctrl.sv
// Directed bench for dru_lock_ctrl with shortened windows so every
// sequence (including timeout and relock-counter saturation) fits a short run.
module tb_dru_lock_ctrl;

    localparam int P_RST  = 16;
    localparam int P_WIN  = 16;
    localparam int P_EXP  = 80;
    localparam int P_TOL  = 4;
    localparam int P_LOCK = 4;
    localparam int P_TO   = 8;
    localparam int P_FILT = 8;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RESET = 3'd1;
    localparam logic [2:0] S_ACQ   = 3'd2;
    localparam logic [2:0] S_TRACK = 3'd3;
    localparam logic [2:0] S_ALARM = 3'd4;

    localparam logic [36:0] CF_A = 37'h01_2345_6789;
    localparam logic [36:0] CF_B = 37'h1F_0000_00AB;

    logic        CLK, RST, i_start, i_stop, i_al_ppm;
    logic [36:0] i_center_f;
    logic [4:0]  i_g1_acq, i_g1_trk, i_g1_p, i_g2;
    logic [3:0]  i_samv;
    logic        o_dru_en, o_dru_rst, o_dru_rst_freq, o_locked;
    logic [4:0]  o_g1, o_g1_p, o_g2;
    logic [36:0] o_center_f;
    logic [2:0]  o_state;
    logic [7:0]  o_relock_cnt;

    int n_pass;
    int n_tot;

    typedef struct {
        logic [3:0] base;
        logic [3:0] last;
        logic [2:0] st;
        logic       locked;
        logic [4:0] g1;
    } vec_t;

    vec_t vecs [10];

    dru_lock_ctrl #(
        .RST_CYCLES(P_RST), .WIN_LEN(P_WIN), .EXP_BITS(P_EXP), .TOL(P_TOL),
        .LOCK_WINDOWS(P_LOCK), .ACQ_TIMEOUT(P_TO), .ALARM_FILT(P_FILT)
    ) dut (
        .CLK(CLK), .RST(RST), .i_start(i_start), .i_stop(i_stop),
        .i_center_f(i_center_f), .i_g1_acq(i_g1_acq), .i_g1_trk(i_g1_trk),
        .i_g1_p(i_g1_p), .i_g2(i_g2), .i_al_ppm(i_al_ppm), .i_samv(i_samv),
        .o_dru_en(o_dru_en), .o_dru_rst(o_dru_rst), .o_dru_rst_freq(o_dru_rst_freq),
        .o_g1(o_g1), .o_g1_p(o_g1_p), .o_g2(o_g2), .o_center_f(o_center_f),
        .o_locked(o_locked), .o_state(o_state), .o_relock_cnt(o_relock_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #900000;
        $display("FAIL watchdog: end of test not reached");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One full window: base SAMV for all cycles but the last
    task automatic run_window(input logic [3:0] base, input logic [3:0] last);
        for (int c = 0; c < P_WIN; c++) begin
            i_samv = (c == P_WIN - 1) ? last : base;
            tick();
        end
        i_samv = base;
    endtask

    // Called while the first RESET cycle is visible; measures the hold
    task automatic wait_reset(input string tag);
        int   n;
        logic ok;
        n  = 0;
        ok = 1'b1;
        while (o_state == S_RESET && n < 100) begin
            if (!(o_dru_rst && o_dru_rst_freq && !o_dru_en)) ok = 1'b0;
            n++;
            tick();
        end
        chk({tag, "_rst_cycles"}, n, 16);
        chk({tag, "_rst_held"}, ok, 1);
        chk({tag, "_acq_entry"}, {o_state, o_dru_en, o_dru_rst, o_dru_rst_freq},
            {S_ACQ, 3'b100});
    endtask

    // Four clean windows of SAMV=5 from the start of ACQ
    task automatic lock_run(input string tag);
        for (int w = 0; w < P_LOCK; w++) begin
            run_window(4'd5, 4'd5);
            chk($sformatf("%s_w%0d_state", tag, w), o_state,
                (w == P_LOCK - 1) ? S_TRACK : S_ACQ);
        end
        chk({tag, "_locked_g1"}, {o_locked, o_g1}, {1'b1, 5'd9});
    endtask

    initial begin
        int n_alarm;
        int cyc;
        n_pass = 0;
        n_tot  = 0;
        RST = 1'b1; i_start = 1'b0; i_stop = 1'b0; i_al_ppm = 1'b0; i_samv = 4'd5;
        i_center_f = CF_A; i_g1_acq = 5'd3; i_g1_trk = 5'd9; i_g1_p = 5'd7; i_g2 = 5'd11;

        // per-window stimulus and expected state after that window closes
        vecs[0] = '{4'd5, 4'd5,  S_ACQ,   1'b0, 5'd3};  // 80 good
        vecs[1] = '{4'd5, 4'd5,  S_ACQ,   1'b0, 5'd3};  // 80 good
        vecs[2] = '{4'd5, 4'd10, S_ACQ,   1'b0, 5'd3};  // 85 bad, count restarts
        vecs[3] = '{4'd5, 4'd9,  S_ACQ,   1'b0, 5'd3};  // 84 good
        vecs[4] = '{4'd5, 4'd1,  S_ACQ,   1'b0, 5'd3};  // 76 good
        vecs[5] = '{4'd5, 4'd5,  S_ACQ,   1'b0, 5'd3};  // 80 good
        vecs[6] = '{4'd5, 4'd5,  S_TRACK, 1'b1, 5'd9};  // 4th good -> lock
        vecs[7] = '{4'd5, 4'd5,  S_TRACK, 1'b1, 5'd9};
        vecs[8] = '{4'd5, 4'd9,  S_TRACK, 1'b1, 5'd9};  // 84 still fine
        vecs[9] = '{4'd5, 4'd0,  S_ALARM, 1'b0, 5'd3};  // 75 bad in TRACK

        tick(); tick();
        chk("rst_ctrl", {o_state, o_dru_en, o_dru_rst, o_dru_rst_freq, o_locked},
            {S_IDLE, 4'b0110});
        chk("rst_gains", {o_g1, o_g1_p, o_g2}, 15'd0);
        chk("rst_cf", o_center_f, 37'd0);
        chk("rst_relock", o_relock_cnt, 8'd0);
        RST = 1'b0;
        tick();
        chk("idle_state", {o_state, o_dru_en, o_dru_rst}, {S_IDLE, 2'b01});

        // first start: configuration capture and reset hold
        i_start = 1'b1;
        tick();
        chk("start1_state", o_state, S_RESET);
        chk("start1_cf", o_center_f, CF_A);
        chk("start1_gains", {o_g1, o_g1_p, o_g2}, {5'd3, 5'd7, 5'd11});
        i_g1_p = 5'd20;
        wait_reset("start1");

        // table of windows: tolerance edges, delayed lock, bad window in TRACK
        for (int i = 0; i < 10; i++) begin
            if (i == 7) i_center_f = CF_B;
            run_window(vecs[i].base, vecs[i].last);
            chk($sformatf("vec%0d_state", i), o_state, vecs[i].st);
            chk($sformatf("vec%0d_lock_g1", i), {o_locked, o_g1}, {vecs[i].locked, vecs[i].g1});
        end
        chk("alarm1_relock", o_relock_cnt, 8'd1);
        chk("alarm1_en", o_dru_en, 1'b0);
        chk("cfg_held_cf", o_center_f, CF_A);
        chk("cfg_held_g1p", o_g1_p, 5'd7);
        tick();
        wait_reset("relock1");

        // AL_PPM run of 7: filter holds, but the sticky flag spoils the window
        lock_run("lock2");
        i_al_ppm = 1'b1;
        repeat (7) tick();
        i_al_ppm = 1'b0;
        repeat (3) tick();
        chk("ppm7_track", o_state, S_TRACK);
        repeat (5) tick();
        chk("ppm7_track_last", o_state, S_TRACK);
        tick();
        chk("ppm7_win_alarm", o_state, S_ALARM);
        chk("ppm7_relock", o_relock_cnt, 8'd2);
        tick();
        wait_reset("relock2");

        // AL_PPM run of 8: filter expiry
        lock_run("lock3");
        i_al_ppm = 1'b1;
        repeat (7) tick();
        chk("ppm8_pre", o_state, S_TRACK);
        tick();
        chk("ppm8_alarm", {o_state, o_locked, o_dru_en}, {S_ALARM, 2'b00});
        chk("ppm8_relock", o_relock_cnt, 8'd3);
        i_al_ppm = 1'b0;
        tick();
        wait_reset("relock3");

        // stop in ACQ, then restart picks up the new configuration
        repeat (5) tick();
        i_start = 1'b0;
        i_stop  = 1'b1;
        tick();
        i_stop = 1'b0;
        chk("stop_acq", {o_state, o_dru_en, o_dru_rst, o_dru_rst_freq}, {S_IDLE, 3'b011});
        tick();
        chk("stop_acq_hold", o_state, S_IDLE);
        i_start = 1'b1;
        tick();
        chk("start2_state", o_state, S_RESET);
        chk("start2_cf", o_center_f, CF_B);
        chk("start2_g1p", o_g1_p, 5'd20);
        wait_reset("start2");
        lock_run("lock4");
        repeat (3) tick();
        i_start = 1'b0;
        i_stop  = 1'b1;
        tick();
        i_stop = 1'b0;
        chk("stop_trk", {o_state, o_dru_en, o_dru_rst, o_dru_rst_freq, o_locked},
            {S_IDLE, 4'b0110});

        // no recovered bits: timeout after exactly P_TO windows
        i_samv  = 4'd0;
        i_start = 1'b1;
        tick();
        wait_reset("start3");
        for (int w = 0; w < P_TO; w++) begin
            run_window(4'd0, 4'd0);
            chk($sformatf("to_w%0d", w), o_state, (w == P_TO - 1) ? S_ALARM : S_ACQ);
        end
        chk("to_relock", o_relock_cnt, 8'd4);

        // repeated timeouts drive the relock counter into saturation
        i_samv   = 4'd5;
        i_al_ppm = 1'b1;
        n_alarm  = 0;
        cyc      = 0;
        while (n_alarm < 296 && cyc < 60000) begin
            tick();
            cyc++;
            if (o_state == S_ALARM) begin
                n_alarm++;
                if (n_alarm == 250) chk("sat_254", o_relock_cnt, 8'd254);
                if (n_alarm == 251) chk("sat_255", o_relock_cnt, 8'd255);
            end
        end
        chk("sat_alarm_count", n_alarm, 296);
        chk("sat_final", o_relock_cnt, 8'd255);

        // asynchronous reset in the middle of TRACK
        i_al_ppm = 1'b0;
        tick();
        wait_reset("start4");
        lock_run("lock5");
        tick(); tick();
        #3;
        RST = 1'b1;
        #1;
        chk("arst_ctrl", {o_state, o_dru_en, o_dru_rst, o_dru_rst_freq, o_locked},
            {S_IDLE, 4'b0110});
        chk("arst_gains", {o_g1, o_g1_p, o_g2}, 15'd0);
        chk("arst_cf", o_center_f, 37'd0);
        chk("arst_relock", o_relock_cnt, 8'd0);
        i_start = 1'b0;
        #10;
        RST = 1'b0;
        tick();
        chk("arst_idle", {o_state, o_relock_cnt}, {S_IDLE, 8'd0});

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
